// File: rtl/encrypt_sequencer.sv
// encrypt_sequencer: loads three configuration bytes, then writes a 64-byte
// frame of LFSR-encrypted characters (preamble spaces, message, trailing
// spaces) with a parity bit in bit 7 of each output byte.
module encrypt_sequencer #(
   parameter int MSG_BASE = 0,
   parameter int CFG_BASE = 61,
   parameter int OUT_BASE = 64,
   parameter int MAX_MSG  = 49
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
);

   localparam logic [7:0] MSG_B = 8'(MSG_BASE);
   localparam logic [7:0] CFG_B = 8'(CFG_BASE);
   localparam logic [7:0] OUT_B = 8'(OUT_BASE);
   localparam logic [6:0] MAX_L = 7'(MAX_MSG);

   typedef enum logic [2:0] {IDLE, LD_PRE, LD_PT, LD_INIT, RD, WR, DONE} state_t;

   state_t     state_q;
   logic [5:0] i_q, pre_q;
   logic [6:0] lfsr_q, taps_q;
   logic       ack_q, wr_en_q;
   logic [7:0] addr_q, wdata_q;

   logic [6:0] char_d, x_d, lfsr_d;
   logic [7:0] wdata_d;

   // Byte index idx falls inside the message window (after the preamble,
   // and not past the longest allowed message).
   function automatic logic in_msg(input logic [5:0] idx, input logic [5:0] pre);
      logic [5:0] k;
      k = idx - pre;
      return (idx >= pre) && ({1'b0, k} < MAX_L);
   endfunction

   // Message address for byte idx; only meaningful when in_msg() holds.
   function automatic logic [7:0] rd_addr(input logic [5:0] idx, input logic [5:0] pre);
      logic [5:0] k;
      k = idx - pre;
      return MSG_B + {2'b00, k};
   endfunction

   // Tap polynomial selected by pt_no; 8 is the only code using bit 3.
   function automatic logic [6:0] tap_of(input logic [3:0] p);
      if (p == 4'd8) return 7'h7B;
      case (p[2:0])
         3'd0:    return 7'h60;
         3'd1:    return 7'h48;
         3'd2:    return 7'h78;
         3'd3:    return 7'h72;
         3'd4:    return 7'h6A;
         3'd5:    return 7'h69;
         3'd6:    return 7'h5C;
         default: return 7'h7E;
      endcase
   endfunction

   // Encrypted byte for the current RD cycle and the LFSR step taken after WR.
   always_comb begin
      char_d  = in_msg(i_q, pre_q) ? mem_rd_data[6:0] : 7'h20;
      x_d     = char_d ^ lfsr_q;
      wdata_d = {^x_d, x_d};
      lfsr_d  = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
   end

   // Sequencer FSM with registered memory-side outputs and Ack.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         pre_q   <= '0;
         lfsr_q  <= 7'h01;
         taps_q  <= 7'h60;
         ack_q   <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (Start && (state_q inside {LD_PRE, LD_PT, LD_INIT, RD, WR})) begin
            // Abort: drop back to IDLE, completed writes stay in memory.
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (!Start) begin
                  state_q <= LD_PRE;
                  addr_q  <= CFG_B;
               end
               LD_PRE: begin
                  pre_q   <= (mem_rd_data > 8'd63) ? 6'd63 : mem_rd_data[5:0];
                  addr_q  <= CFG_B + 8'd1;
                  state_q <= LD_PT;
               end
               LD_PT: begin
                  taps_q  <= tap_of(mem_rd_data[3:0]);
                  addr_q  <= CFG_B + 8'd2;
                  state_q <= LD_INIT;
               end
               LD_INIT: begin
                  // An all-zero LFSR would lock up, so seed 0 maps to 1.
                  lfsr_q  <= (mem_rd_data[6:0] == 7'h00) ? 7'h01 : mem_rd_data[6:0];
                  i_q     <= '0;
                  addr_q  <= rd_addr(6'd0, pre_q);
                  state_q <= RD;
               end
               RD: begin
                  wdata_q <= wdata_d;
                  addr_q  <= OUT_B + {2'b00, i_q};
                  wr_en_q <= 1'b1;
                  state_q <= WR;
               end
               WR: begin
                  lfsr_q <= lfsr_d;
                  if (i_q == 6'd63) begin
                     addr_q  <= '0;
                     state_q <= DONE;
                  end else begin
                     i_q     <= i_q + 6'd1;
                     addr_q  <= rd_addr(i_q + 6'd1, pre_q);
                     state_q <= RD;
                  end
               end
               DONE: begin
                  if (Start) begin
                     ack_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     ack_q   <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Ack         = ack_q;
   assign mem_addr    = addr_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_data = wdata_q;

endmodule

// File: doc/encrypt_sequencer.md
ENCRYPT_SEQUENCER -- requirements
Module: encrypt_sequencer

Interface
REQ-001 The block SHALL have parameter MSG_BASE, default 0, meaning data-memory address of message byte 0.
REQ-002 The block SHALL have parameter CFG_BASE, default 61, meaning address of pre_length; CFG_BASE+1 holds pt_no and CFG_BASE+2 holds LFSR_init.
REQ-003 The block SHALL have parameter OUT_BASE, default 64, meaning address of encrypted byte 0.
REQ-004 The block SHALL have parameter MAX_MSG, default 49, meaning the maximum number of message characters.
REQ-005 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have port Start, input, 1; high holds the block idle, and low launches or continues a run.
REQ-008 The block SHALL have port Ack, output, 1, asserted to mean the run is complete.
REQ-009 The block SHALL have port mem_addr, output, 8, the data-memory address.
REQ-010 The block SHALL have port mem_rd_data, input, 8, combinational read data for mem_addr in the same cycle.
REQ-011 The block SHALL have port mem_wr_en, output, 1, the write strobe, sampled by memory on the rising edge.
REQ-012 The block SHALL have port mem_wr_data, output, 8, the write data.

Function
REQ-013 The FSM SHALL have the states IDLE, LD_PRE, LD_PT, LD_INIT, RD, WR and DONE.
REQ-014 In IDLE with Start low, the FSM SHALL go to LD_PRE next cycle; with Start high it SHALL stay in IDLE.
REQ-015 LD_PRE, LD_PT and LD_INIT SHALL each take 1 cycle, drive mem_addr=CFG_BASE, CFG_BASE+1 and CFG_BASE+2 respectively, and capture mem_rd_data at the cycle end.
REQ-016 pt_no decode: if pt_no[3:0]==8 then index 8, else index pt_no[2:0].
REQ-017 The tap table SHALL be {0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B} for indices 0..8.
REQ-018 The LFSR state SHALL be loaded with LFSR_init[6:0], and 0 SHALL be replaced by 7'h01.
REQ-019 pre_length values above 63 SHALL saturate to 63.
REQ-020 A 6-bit byte counter i SHALL start at 0 after LD_INIT.
REQ-021 In RD, with k=i-pre_length: if i>=pre_length and k<MAX_MSG, mem_addr SHALL be MSG_BASE+k and the character SHALL be mem_rd_data captured; otherwise char=0x20 and mem_addr is don't-care; mem_wr_en SHALL be 0.
REQ-022 In WR, with x=char XOR {1'b0,lfsr}, the block SHALL drive mem_addr=OUT_BASE+i, mem_wr_data={^x[6:0], x[6:0]} and mem_wr_en=1 for exactly one cycle.
REQ-023 At the end of WR, lfsr SHALL update to {lfsr[5:0], ^(lfsr & taps)}; if i==63 the FSM SHALL go to DONE, else i increments and the FSM returns to RD.
REQ-024 Exactly 64 writes SHALL occur per run, each RD/WR pair taking 2 cycles.
REQ-025 Ack SHALL first be high 132 cycles after the IDLE->LD_PRE edge: 3 configuration cycles plus 128 byte cycles plus 1.
REQ-026 In DONE, Ack SHALL be 1; Ack SHALL remain 1 while Start is low, and the FSM SHALL go to IDLE on the cycle after Start is sampled high.
REQ-027 Ack SHALL be 0 in all states other than DONE.
REQ-028 Abort: Start sampled high in any of LD_PRE..WR SHALL return the FSM to IDLE next cycle, Ack SHALL stay 0, and mem_wr_en SHALL be 0 from that cycle; writes already completed remain.
REQ-029 A run SHALL never overwrite addresses below OUT_BASE.
REQ-030 mem_wr_en SHALL be 0 in every state except WR.

Reset
REQ-031 When Reset is sampled low, the block SHALL enter IDLE with Ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, i=0, lfsr=7'h01, taps=0x60 and pre_length=0.
REQ-032 Reset SHALL override Start and all run states, including asserting Reset mid-run or in DONE.
REQ-033 Reset deassertion with Start already low SHALL launch a run on the first non-reset cycle.

Verification
REQ-034 Scenario: pre=10, pt_no=6, init=0x01, message "Mr. Watson, come here. I want to see you." -> OUT[0..3] = 0x21, 0x22, 0x24, 0xA9; all 64 bytes match the golden model; Ack occurs at cycle 132.
REQ-035 Scenario: init=0x00, pre=10 -> behaviour identical to init=0x01.
REQ-036 Scenario: pt_no=0x08 and pt_no=0x0E -> taps 0x7B and 0x5C respectively.
REQ-037 Scenario: 60-character message, pre=15 -> only characters 0..48 are used; OUT[k] for k>=64 is encrypted space; no write to addresses 0..63.
REQ-038 Scenario: Start raised at byte 20 -> exactly 20 writes, Ack stays 0, FSM is in IDLE; a new run with Start low completes correctly.
REQ-039 Scenario: Reset low during WR of byte 5 -> no further writes; after release, a full run gives correct output and Ack holds until Start goes high.
